tl_multi_cntr: RTL

TL_MULTI_CNTR -- requirements
Module: tl_multi_cntr

---
 rtl/tl_pkg.sv | 26 ++
 rtl/tl_rr_arb.sv | 33 +++
 rtl/tl_multi_cntr.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// tl_pkg -- shared definitions for the multi-approach traffic light controller.
//   Light codes driven on each approach's 2-bit light field, the FSM state
//   encoding, and a small max() helper used to size the phase counter.
//   Optional feature macro: TL_PED_EN (adds the WALK state).
package tl_pkg;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
`ifdef TL_PED_EN
        ST_ALL_RED = 2'd2,
        ST_WALK    = 2'd3
`else
        ST_ALL_RED = 2'd2
`endif
    } tl_state_e;

    function automatic int tl_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_rr_arb.sv
// tl_rr_arb -- round-robin search for the next requesting approach.
//   req : request vector, one bit per approach
//   cur : index of the approach that currently owns the green
//   nxt : first requesting index after cur (wrapping), excluding cur;
//         cur+1 (mod N) when no other approach requests
//   any : high when at least one approach other than cur requests
module tl_rr_arb #(
    parameter int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] cur,
    output logic [IW-1:0] nxt,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        nxt = IW'((int'(cur) + 1) % N);
        any = 1'b0;
        idx = '0;
        // Offsets start at 1 so the current owner is never selected.
        for (int k = 1; k < N; k++) begin
            idx = IW'((int'(cur) + k) % N);
            if (!any && req[idx]) begin
                nxt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_multi_cntr.sv
// tl_multi_cntr -- N_DIR-approach traffic light controller with demand-driven
// green extension and round-robin handover.
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   sensor     : vehicle waiting, one bit per approach
//   light      : 2-bit code per approach (GREEN=00, YELLOW=01, RED=10)
//   active_dir : approach owning the current green/yellow phase
//   ped_req    : pedestrian request pulse          (TL_PED_EN only)
//   walk       : walk indication, all approaches RED (TL_PED_EN only)
// Optional feature macro: TL_PED_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// GREEN   | active_dir green; held until competing demand and timers allow
// YELLOW  | active_dir yellow for T_YELLOW cycles, next_dir already latched
// ALL_RED | clearance for T_ALL_RED cycles, then ownership moves to next_dir
// WALK    | pedestrian phase, all RED for T_WALK cycles (TL_PED_EN only)
module tl_multi_cntr
    import tl_pkg::*;
#(
    parameter int N_DIR       = 4,
    parameter int T_MIN_GREEN = 4,
    parameter int T_MAX_GREEN = 10,
    parameter int T_YELLOW    = 2,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_DIR-1:0]           sensor,
`ifdef TL_PED_EN
    input  logic                       ped_req,
    output logic                       walk,
`endif
    output logic [2*N_DIR-1:0]         light,
    output logic [$clog2(N_DIR)-1:0]   active_dir
);

    localparam int IDX_W   = $clog2(N_DIR);
    localparam int CNT_MAX = tl_max(tl_max(T_MIN_GREEN, T_MAX_GREEN),
                                    tl_max(tl_max(T_YELLOW, T_ALL_RED), T_WALK));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] WLK_LAST = CNT_W'(T_WALK - 1);

    tl_state_e          state_q,      state_d;
    logic [IDX_W-1:0]   active_dir_q, active_dir_d;
    logic [IDX_W-1:0]   next_dir_q,   next_dir_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
`ifdef TL_PED_EN
    logic               ped_pend_q,   ped_pend_d;
`endif

    logic [IDX_W-1:0]   arb_next;
    logic               arb_any;
    logic               other_demand;
    logic               green_exit;

    tl_rr_arb #(.N(N_DIR)) u_rr_arb (
        .req (sensor),
        .cur (active_dir_q),
        .nxt (arb_next),
        .any (arb_any)
    );

`ifdef TL_PED_EN
    assign other_demand = arb_any | ped_pend_q;
`else
    assign other_demand = arb_any;
`endif

    // Own demand only delays the handover until the max-green limit.
    assign green_exit = (cnt_q >= MIN_LAST) && other_demand &&
                        (!sensor[active_dir_q] || (cnt_q >= MAX_LAST));

    always_comb begin
        state_d      = state_q;
        active_dir_d = active_dir_q;
        next_dir_d   = next_dir_q;
        case (state_q)
            ST_GREEN: begin
                if (green_exit) begin
                    state_d    = ST_YELLOW;
                    next_dir_d = arb_next;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_LAST) state_d = ST_ALL_RED;
            end
            ST_ALL_RED: begin
                if (cnt_q == AR_LAST) begin
                    active_dir_d = next_dir_q;
`ifdef TL_PED_EN
                    state_d      = ped_pend_q ? ST_WALK : ST_GREEN;
`else
                    state_d      = ST_GREEN;
`endif
                end
            end
`ifdef TL_PED_EN
            ST_WALK: begin
                if (cnt_q == WLK_LAST) state_d = ST_GREEN;
            end
`endif
            default: state_d = ST_GREEN;
        endcase

        // Every state entry restarts the counter; it saturates while green holds.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
        else                     cnt_d = cnt_q;
    end

`ifdef TL_PED_EN
    // A request arriving on the WALK entry cycle survives for the next round.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_pend_d = 1'b0;
        if (ped_req)                                  ped_pend_d = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_GREEN;
            active_dir_q <= '0;
            next_dir_q   <= '0;
            cnt_q        <= '0;
`ifdef TL_PED_EN
            ped_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            active_dir_q <= active_dir_d;
            next_dir_q   <= next_dir_d;
            cnt_q        <= cnt_d;
`ifdef TL_PED_EN
            ped_pend_q   <= ped_pend_d;
`endif
        end
    end

    always_comb begin
        light = {N_DIR{LIGHT_RED}};
        case (state_q)
            ST_GREEN:  light[2*int'(active_dir_q) +: 2] = LIGHT_GREEN;
            ST_YELLOW: light[2*int'(active_dir_q) +: 2] = LIGHT_YELLOW;
            default:   ;
        endcase
    end

    assign active_dir = active_dir_q;
`ifdef TL_PED_EN
    assign walk = (state_q == ST_WALK);
`endif

endmodule
